// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: FSM states, bus layouts and load/store opcodes.
// Field offsets mirror the packed bus structs below (MSB first).
package mem_pkg;

   localparam int MEM_DATA_W = 32;
   localparam int MEM_EX_W   = 138;
   localparam int MEM_WB_W   = 103;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   // IR[31:22] opcodes
   localparam logic [9:0] OP_LD_B  = 10'h0a0;
   localparam logic [9:0] OP_LD_H  = 10'h0a1;
   localparam logic [9:0] OP_LD_W  = 10'h0a2;
   localparam logic [9:0] OP_ST_B  = 10'h0a4;
   localparam logic [9:0] OP_ST_H  = 10'h0a5;
   localparam logic [9:0] OP_ST_W  = 10'h0a6;
   localparam logic [9:0] OP_LD_BU = 10'h0a8;
   localparam logic [9:0] OP_LD_HU = 10'h0a9;

   localparam int EX_RESULT_LSB   = 0;
   localparam int EX_WADDR_LSB    = 32;
   localparam int EX_RKD_LSB      = 37;
   localparam int EX_GR_WE        = 69;
   localparam int EX_RES_FROM_MEM = 70;
   localparam int EX_MEM_WE       = 71;
   localparam int EX_INST_LD_W    = 72;
   localparam int EX_IR_LSB       = 73;
   localparam int EX_PC_LSB       = 105;
   localparam int EX_VALID        = 137;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] ir;
      logic        inst_ld_w;
      logic        mem_we;
      logic        res_from_mem;
      logic        gr_we;
      logic [31:0] rkd_value;
      logic [4:0]  rf_waddr;
      logic [31:0] result;
   } ex_bus_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] ir;
      logic        gr_we;
      logic [4:0]  rf_waddr;
      logic [31:0] final_result;
   } wb_bus_t;

endpackage

// File: rtl/mem_align.sv
// Sub-word store lane/strobe generation and load byte/half extract with sign/zero extension.
// Latency: combinational. Backpressure: none (pure function of its inputs).
module mem_align
   import mem_pkg::*;
(
   input  logic [9:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic        mem_we,
   input  logic [31:0] rkd,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_val
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      wstrb = mem_we ? 4'hf : 4'h0;
      wdata = rkd;
      if (mem_we) begin
         case (op)
            OP_ST_B: begin
               wstrb = 4'b0001 << addr_lo;
               wdata = {4{rkd[7:0]}};
            end
            OP_ST_H: begin
               wstrb = 4'b0011 << {addr_lo[1], 1'b0};
               wdata = {2{rkd[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         OP_LD_B:  load_val = {{24{byte_sel[7]}}, byte_sel};
         OP_LD_BU: load_val = {24'h0, byte_sel};
         OP_LD_H:  load_val = {{16{half_sel[15]}}, half_sel};
         OP_LD_HU: load_val = {16'h0, half_sel};
         default:  load_val = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-SRAM req/addr_ok/data_ok transactions, forwards to ID, feeds WB.
// Latency 1 cycle for non-memory ops; memops add addr_ok wait + memory latency. Holds (MEM_allowin=0) until done and WB accepts.
// MEM_SUBWORD_EN adds ld.b/h(u) and st.b/h via mem_align; default build is word-only.
module mem_stage
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int EX_W   = MEM_EX_W,
   parameter int WB_W   = MEM_WB_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [EX_W-1:0]   EX_to_MEM_reg,
   input  logic              WB_allowin,
   output logic              MEM_allowin,
   output logic              data_sram_req,
   output logic              data_sram_wr,
   output logic [3:0]        data_sram_wstrb,
   output logic [DATA_W-1:0] data_sram_addr,
   output logic [DATA_W-1:0] data_sram_wdata,
   input  logic              data_sram_addr_ok,
   input  logic              data_sram_data_ok,
   input  logic [DATA_W-1:0] data_sram_rdata,
   output logic              front_valid,
   output logic [4:0]        front_addr,
   output logic [DATA_W-1:0] front_data,
   output logic              front_stall,
   output logic [WB_W-1:0]   MEM_to_WB_reg
);

   ex_bus_t     ex;
   wb_bus_t     wb_nxt;
   mem_state_t  state, state_nxt;
   logic        memop;
   logic        readygo;
   logic [31:0] rdata_buf;
   logic [31:0] final_result;
   logic        unused_ld_w;

   assign ex          = EX_to_MEM_reg;
   assign memop       = ex.valid & (ex.mem_we | ex.res_from_mem);
   assign unused_ld_w = ex.inst_ld_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      data_sram_req = 1'b0;
      case (state)
         ST_IDLE: begin
            data_sram_req = memop;
            if (memop && data_sram_addr_ok) state_nxt = ST_WAIT;
         end
         ST_WAIT: if (data_sram_data_ok) state_nxt = ST_DONE;
         ST_DONE: if (WB_allowin) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // data_ok is only meaningful while a request is outstanding
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        rdata_buf <= '0;
      else if (state == ST_WAIT && data_sram_data_ok) rdata_buf <= data_sram_rdata;
   end

   assign readygo     = (state == ST_IDLE && ex.valid && !memop) || (state == ST_DONE);
   assign MEM_allowin = !ex.valid || (readygo && WB_allowin);

   assign data_sram_wr   = ex.mem_we;
   assign data_sram_addr = ex.result;

`ifdef MEM_SUBWORD_EN
   logic [31:0] load_val;

   mem_align u_mem_align (
      .op       (ex.ir[31:22]),
      .addr_lo  (ex.result[1:0]),
      .mem_we   (ex.mem_we),
      .rkd      (ex.rkd_value),
      .rdata    (rdata_buf),
      .wstrb    (data_sram_wstrb),
      .wdata    (data_sram_wdata),
      .load_val (load_val)
   );

   assign final_result = ex.res_from_mem ? load_val : ex.result;
`else
   assign data_sram_wstrb = ex.mem_we ? 4'hf : 4'h0;
   assign data_sram_wdata = ex.rkd_value;
   assign final_result    = ex.res_from_mem ? rdata_buf : ex.result;
`endif

   assign front_valid = ex.valid && ex.gr_we && (!ex.res_from_mem || state == ST_DONE);
   assign front_addr  = ex.rf_waddr;
   assign front_data  = final_result;
   assign front_stall = ex.valid && ex.res_from_mem && (state != ST_DONE);

   always_comb begin
      wb_nxt              = '0;
      wb_nxt.valid        = ex.valid;
      wb_nxt.pc           = ex.pc;
      wb_nxt.ir           = ex.ir;
      wb_nxt.gr_we        = ex.gr_we;
      wb_nxt.rf_waddr     = ex.rf_waddr;
      wb_nxt.final_result = final_result;
   end

   // a bubble is written into WB whenever WB can take something but MEM is not ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             MEM_to_WB_reg <= '0;
      else if (WB_allowin) MEM_to_WB_reg <= readygo ? wb_nxt : '0;
   end

   no_second_data_ok: assert property (@(posedge clk) disable iff (rst)
      !(state == ST_DONE && data_sram_data_ok));

endmodule

// File: tb/tb_mem_stage.sv
// Directed literal checks followed by randomized traffic against a transaction-level model of the MEM stage.
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic [137:0] ex_bus;
   logic         wb_allowin, mem_allowin;
   logic         req, wr, addr_ok, data_ok;
   logic [3:0]   wstrb;
   logic [31:0]  addr, wdata, rdata;
   logic         fv, fs;
   logic [4:0]   fa;
   logic [31:0]  fd;
   logic [102:0] wb;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] IR_ADD  = 32'h00100000;
   localparam logic [31:0] IR_LDW  = 32'h28800000;
   localparam logic [31:0] IR_STW  = 32'h29800000;
   localparam logic [31:0] IR_LDB  = 32'h28000000;
   localparam logic [31:0] IR_LDBU = 32'h2A000000;
   localparam logic [31:0] IR_STH  = 32'h29400000;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk               (clk),
      .rst               (rst),
      .EX_to_MEM_reg     (ex_bus),
      .WB_allowin        (wb_allowin),
      .MEM_allowin       (mem_allowin),
      .data_sram_req     (req),
      .data_sram_wr      (wr),
      .data_sram_wstrb   (wstrb),
      .data_sram_addr    (addr),
      .data_sram_wdata   (wdata),
      .data_sram_addr_ok (addr_ok),
      .data_sram_data_ok (data_ok),
      .data_sram_rdata   (rdata),
      .front_valid       (fv),
      .front_addr        (fa),
      .front_data        (fd),
      .front_stall       (fs),
      .MEM_to_WB_reg     (wb)
   );

   function automatic logic [137:0] mk(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                                       input logic ldw, input logic st, input logic ld, input logic gw,
                                       input logic [31:0] rkd, input logic [4:0] wa, input logic [31:0] res);
      return {v, pc, ir, ldw, st, ld, gw, rkd, wa, res};
   endfunction

   function automatic logic [102:0] wbv(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                                        input logic gw, input logic [4:0] wa, input logic [31:0] fin);
      return {v, pc, ir, gw, wa, fin};
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [102:0] act, input logic [102:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- transaction-level model ----------------
   bit           rnd_on = 1'b0;
   logic [137:0] cur;
   bit           acc, got;
   int           lat;
   logic [31:0]  fin;
   logic [31:0]  mem [16];
   logic [31:0]  pc_ctr;
   logic [102:0] exp_wb;
   bit           exp_req, exp_allowin, exp_fv, exp_fs;
   logic [31:0]  exp_fd;

   function automatic bit is_ld();  return cur[137] & cur[70]; endfunction
   function automatic bit is_st();  return cur[137] & cur[71]; endfunction

   task automatic new_inst();
      int kind;
      logic [31:0] a;
      acc = 1'b0;
      got = 1'b0;
      fin = 32'h0;
      a   = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      kind = $urandom_range(0, 3);
      pc_ctr += 32'h4;
      case (kind)
         0: cur = '0;
         1: cur = mk(1'b1, pc_ctr, $urandom & 32'h003fffff, 1'b0, 1'b0, 1'b0, 1'($urandom),
                     $urandom, 5'($urandom), $urandom);
         2: cur = mk(1'b1, pc_ctr, IR_LDW | ($urandom & 32'h003fffff), 1'b1, 1'b0, 1'b1, 1'b1,
                     $urandom, 5'($urandom), a);
         default: cur = mk(1'b1, pc_ctr, IR_STW | ($urandom & 32'h003fffff), 1'b0, 1'b1, 1'b0, 1'b0,
                           $urandom, 5'($urandom), a);
      endcase
   endtask

   task automatic drive_and_expect();
      bit v, memop;
      v     = cur[137];
      memop = is_ld() | is_st();
      ex_bus     = cur;
      wb_allowin = ($urandom_range(0, 9) < 7);
      addr_ok    = 1'($urandom);
      rdata      = $urandom;
      if (acc && !got) begin
         if (lat == 0) begin
            data_ok = 1'b1;
            if (is_ld()) rdata = mem[cur[5:2]];
         end else begin
            data_ok = 1'b0;
            lat--;
         end
      end else if (!acc) begin
         data_ok = ($urandom_range(0, 9) == 0);
      end else begin
         data_ok = 1'b0;
      end
      exp_req     = v & memop & !acc;
      exp_allowin = !v | (v & (!memop | got) & wb_allowin);
      exp_fv      = v & cur[69] & (!cur[70] | got);
      exp_fs      = is_ld() & !got;
      exp_fd      = is_ld() ? fin : cur[31:0];
   endtask

   task automatic model_edge();
      bit v;
      v = cur[137];
      if (wb_allowin)
         exp_wb = (v && exp_allowin)
                ? wbv(1'b1, cur[136:105], cur[104:73], cur[69], cur[36:32], is_ld() ? fin : cur[31:0])
                : '0;
      if (exp_req && addr_ok) begin
         acc = 1'b1;
         lat = $urandom_range(0, 3);
      end else if (acc && !got && data_ok) begin
         got = 1'b1;
         if (is_ld()) fin = rdata;
         else         mem[cur[5:2]] = cur[68:37];
      end
      if (exp_allowin) new_inst();
   endtask

   always @(negedge clk) begin
      if (rnd_on) begin
         chk1("r_allowin", mem_allowin, exp_allowin);
         chk1("r_req", req, exp_req);
         chk1("r_stall", fs, exp_fs);
         chk1("r_fv", fv, exp_fv);
         chkw("r_wb", wb, exp_wb);
         if (exp_fv) begin
            chk32("r_fd", fd, exp_fd);
            chk32("r_fa", {27'b0, fa}, {27'b0, cur[36:32]});
         end
         if (exp_req) begin
            chk32("r_addr", addr, cur[31:0]);
            chk1("r_wr", wr, cur[71]);
            chk32("r_wstrb", {28'b0, wstrb}, cur[71] ? 32'hf : 32'h0);
            if (cur[71]) chk32("r_wdata", wdata, cur[68:37]);
         end
      end
   end

   // ---------------- sequence ----------------
   initial begin
      rst = 1'b1; ex_bus = '0; wb_allowin = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
      #2;
      chk1("rst_allowin", mem_allowin, 1'b1);
      chk1("rst_req", req, 1'b0);
      chkw("rst_wb", wb, '0);
      chk1("rst_fv", fv, 1'b0);
      chk1("rst_stall", fs, 1'b0);
      #10 rst = 1'b0;
      step();

      // non-memory add
      ex_bus = mk(1'b1, 32'h1c000000, IR_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 5'd5, 32'h12);
      wb_allowin = 1'b1;
      #1;
      chk1("add_allowin", mem_allowin, 1'b1);
      chk1("add_fv", fv, 1'b1);
      chk32("add_fd", fd, 32'h12);
      chk32("add_fa", {27'b0, fa}, 32'd5);
      chk1("add_req", req, 1'b0);
      step();
      ex_bus = '0; data_ok = 1'b1; rdata = 32'h55555555;   // stray data_ok while idle
      #1;
      chkw("add_wb", wb, wbv(1'b1, 32'h1c000000, IR_ADD, 1'b1, 5'd5, 32'h12));
      step();

      // ld.w with delayed addr_ok and data_ok
      data_ok = 1'b0; rdata = '0;
      ex_bus = mk(1'b1, 32'h1c000010, IR_LDW, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 5'd7, 32'h1000);
      for (int i = 0; i < 3; i++) begin
         addr_ok = (i == 2);
         #1;
         chk1("ld_req_held", req, 1'b1);
         chk32("ld_addr", addr, 32'h1000);
         chk1("ld_wr", wr, 1'b0);
         chk1("ld_stall", fs, 1'b1);
         chk1("ld_allowin", mem_allowin, 1'b0);
         step();
      end
      addr_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_ok = (i == 2);
         rdata   = (i == 2) ? 32'hDEADBEEF : 32'h0;
         #1;
         chk1("ld_wait_req", req, 1'b0);
         chk1("ld_wait_stall", fs, 1'b1);
         chk1("ld_wait_fv", fv, 1'b0);
         step();
      end
      data_ok = 1'b0; rdata = 32'h0; wb_allowin = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1("hold_allowin", mem_allowin, 1'b0);
         chk1("hold_fv", fv, 1'b1);
         chk1("hold_stall", fs, 1'b0);
         chk32("hold_fd", fd, 32'hDEADBEEF);
         chkw("hold_wb", wb, '0);
         step();
      end
      wb_allowin = 1'b1;
      #1;
      chk1("release_allowin", mem_allowin, 1'b1);
      step();

      // back-to-back st.w
      ex_bus = mk(1'b1, 32'h1c000014, IR_STW, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 5'd0, 32'h2004);
      addr_ok = 1'b1;
      #1;
      chkw("ld_wb", wb, wbv(1'b1, 32'h1c000010, IR_LDW, 1'b1, 5'd7, 32'hDEADBEEF));
      chk1("st_req", req, 1'b1);
      chk1("st_wr", wr, 1'b1);
      chk32("st_wstrb", {28'b0, wstrb}, 32'hf);
      chk32("st_wdata", wdata, 32'hA5A5A5A5);
      chk32("st_addr", addr, 32'h2004);
      chk1("st_fv", fv, 1'b0);
      chk1("st_allowin", mem_allowin, 1'b0);
      step();
      addr_ok = 1'b0; data_ok = 1'b1;
      #1;
      chk1("st_wait_req", req, 1'b0);
      chk1("st_wait_allowin", mem_allowin, 1'b0);
      step();
      data_ok = 1'b0;
      #1;
      chk1("st_done_allowin", mem_allowin, 1'b1);
      step();
      ex_bus = '0;
      #1;
      chkw("st_wb", wb, wbv(1'b1, 32'h1c000014, IR_STW, 1'b0, 5'd0, 32'h2004));
      step();

`ifdef MEM_SUBWORD_EN
      for (int k = 0; k < 2; k++) begin
         ex_bus = mk(1'b1, 32'h1c000020, (k == 0) ? IR_LDB : IR_LDBU, 1'b0, 1'b0, 1'b1, 1'b1,
                     32'h0, 5'd3, 32'h1003);
         addr_ok = 1'b1;
         step();
         addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h80FFFFFF;
         step();
         data_ok = 1'b0; rdata = 32'h0;
         #1;
         chk32((k == 0) ? "ldb_fd" : "ldbu_fd", fd, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
         step();
         ex_bus = '0;
      end
      ex_bus = mk(1'b1, 32'h1c000030, IR_STH, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00001234, 5'd0, 32'h1002);
      #1;
      chk32("sth_wstrb", {28'b0, wstrb}, 32'hC);
      chk32("sth_wdata", wdata, 32'h12341234);
      ex_bus = '0;
      step();
`endif

      // reset while waiting for a load response
      ex_bus = mk(1'b1, 32'h1c000040, IR_LDW, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 5'd9, 32'h1008);
      addr_ok = 1'b1; wb_allowin = 1'b0;
      #1;
      chk1("rw_req", req, 1'b1);
      step();
      addr_ok = 1'b0;
      #1;
      chk1("rw_wait_req", req, 1'b0);
      chk1("rw_wait_stall", fs, 1'b1);
      rst = 1'b1; ex_bus = '0;
      #1;
      chkw("rw_wb", wb, '0);
      chk1("rw_req0", req, 1'b0);
      chk1("rw_stall0", fs, 1'b0);
      chk1("rw_allowin", mem_allowin, 1'b1);
      step();
      rst = 1'b0; wb_allowin = 1'b1;

      // randomized traffic
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      pc_ctr = 32'h1c001000;
      cur = '0; acc = 1'b0; got = 1'b0; lat = 0; fin = '0; exp_wb = '0;
      rnd_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         drive_and_expect();
         @(posedge clk);
         model_edge();
         #1;
      end
      rnd_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of EX; consumes the 138-bit EX-to-MEM register and produces the MEM-to-WB register.
- Issues data-SRAM requests for loads and stores using a req/addr_ok/data_ok handshake.
- Holds the instruction until the response returns.
- Supplies forwarding data and a load-use stall indication to ID.

Parameters:
- DATA_W, 32, data/address width
- EX_W, 138, EX-to-MEM bus width
- WB_W, 103, MEM-to-WB bus width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- EX_to_MEM_reg  in  138  {valid, pc[31:0], IR[31:0], inst_ld_w, mem_we, res_from_mem, gr_we, rkd_value[31:0], rf_waddr[4:0], result[31:0]}
- WB_allowin  in  1  WB can accept
- MEM_allowin  out  1  MEM can accept a new instruction
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1 = store
- data_sram_wstrb  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response / write complete
- data_sram_rdata  in  32  load data
- front_valid  out  1  forwarding value valid
- front_addr  out  5  forwarding destination register
- front_data  out  32  forwarding value
- front_stall  out  1  load in MEM not yet returned; ID must stall consumers
- MEM_to_WB_reg  out  103  {valid, pc, IR, gr_we, rf_waddr, final_result}

Behaviour:
- memop = valid & (mem_we | res_from_mem); addr = result; wdata = rkd_value.
- FSM states: IDLE, WAIT, DONE; async reset to IDLE.
  - IDLE: data_sram_req = memop. If addr_ok & memop, go to WAIT. A non-memop instruction is ready in IDLE (zero extra latency).
  - WAIT: req = 0. data_ok is sampled only here. On data_ok, capture rdata into rdata_buf and go to DONE.
  - DONE: ready. If WB_allowin, go to IDLE.
  - IDLE with memop & ~addr_ok: hold req; addr, wr, wstrb and wdata stay stable.
- readygo = (IDLE & valid & ~memop) | DONE.
- Bubble: ~valid means readygo = 0 and MEM_allowin = 1.
- MEM_allowin = ~valid | readygo & WB_allowin.
- Base configuration (word-only):
  - wstrb = 4'hf when mem_we, else 0.
  - data_sram_wr = mem_we.
  - final_result = res_from_mem ? rdata_buf : result.
- Forwarding:
  - front_valid = valid & gr_we & (~res_from_mem | DONE).
  - front_addr = rf_waddr; front_data = final_result.
  - front_stall = valid & res_from_mem & ~DONE.
- MEM_to_WB_reg:
  - readygo & WB_allowin loads {valid, pc, IR, gr_we, rf_waddr, final_result}.
  - ~readygo & WB_allowin loads all-zero.
  - Otherwise holds.
- Latency:
  - Non-mem: 1 cycle.
  - Memop: 1 cycle after data_ok, plus addr_ok wait, plus memory latency.
- Boundaries:
  - Back-to-back memops: the new instruction arrives on the same edge DONE leaves to IDLE; req may assert that very cycle.
  - WB stalled in DONE: rdata_buf and outputs hold; a second data_ok is illegal (protocol violation; an assertion flags it).
  - data_ok in IDLE is ignored.
  - Reset mid-operation: FSM to IDLE, rdata_buf = 0, MEM_to_WB_reg = 0. The SRAM shares rst, so no stale response exists.
- Reset values: all outputs 0 except MEM_allowin = 1 (combinational from zeroed input).

Optional Feature:
- MEM_SUBWORD_EN. When defined, decode IR[31:22] for ld.b 0x0a0, ld.h 0x0a1, ld.bu 0x0a8, ld.hu 0x0a9, st.b 0x0a4, st.h 0x0a5.
  - st.b: wstrb = 4'b0001 << addr[1:0]; wdata = {4{rkd[7:0]}}.
  - st.h: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = {2{rkd[15:0]}}.
  - Loads: select the byte/half by addr[1:0] and sign- or zero-extend.
- When undefined, only word access as above; addr[1:0] passed through unchanged.

Decomposition:
- Shared header/package mem_pkg:
  - FSM state encodings.
  - Bus widths EX_W and WB_W.
  - Load/store opcode constants.
  - EX-to-MEM field offsets.
- One sub-module, mem_align: combinational wstrb/wdata generation and load extract/extend; instantiated only under MEM_SUBWORD_EN.

Test Plan:
- Non-mem add, result=0x12, gr_we=1, WB_allowin=1 -> same cycle MEM_allowin=1, front_valid=1, front_data=0x12; next edge MEM_to_WB_reg final_result=0x12.
- ld.w addr=0x1000, addr_ok delayed 2 cycles, data_ok 3 cycles later with rdata=0xDEADBEEF -> req held 3 cycles with stable addr; front_stall=1 until DONE; WB gets 0xDEADBEEF.
- st.w addr=0x2004, rkd=0xA5A5A5A5 -> wr=1, wstrb=4'hf, wdata=0xA5A5A5A5; stage ready only after data_ok; gr_we=0 so front_valid=0.
- Load in DONE with WB_allowin=0 for 4 cycles -> MEM_allowin=0, outputs and rdata_buf stable; releases on WB_allowin=1.
- Reset asserted in WAIT -> asynchronously IDLE, MEM_to_WB_reg=0, req=0, front_stall=0.
- MEM_SUBWORD_EN: ld.b addr=0x1003, rdata=0x80FFFFFF -> 0xFFFFFF80; ld.bu -> 0x00000080; st.h addr=0x1002 -> wstrb=4'b1100.
